// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built from one full-adder cell
// and a carry flop. Operands are added LSB-first, one bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start_valid  request to start an operation with the current a/b/cin/sub
//   start_ready  request can be accepted (IDLE only)
//   a, b         WIDTH-bit operands, sampled on the accept edge
//   cin          carry-in for add mode (ignored when sub=1)
//   sub          0: a+b+cin, 1: a-b
//   sum          registered result, held until the next result is written
//   cout         carry out of the MSB (sub mode: 1 = no borrow)
//   overflow     two's-complement overflow of the result
//   busy         operation in flight (RUN or DONE)
//   done         one-cycle pulse when sum/cout/overflow have just been updated

`default_nettype none

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MSB_M1   = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             msb_cin_q;

    logic accept_c;
    logic last_bit_c;
    logic bit_s_c;
    logic carry_nxt_c;

    // Single full-adder cell working on the current LSBs.
    always_comb begin
        bit_s_c     = opa_q[0] ^ opb_q[0] ^ carry_q;
        carry_nxt_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    end

    // Next-state logic and the strobes that steer the datapath.
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        last_bit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_BIT) begin
                    last_bit_c = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status flags are registered copies of the state, so start_ready and
    // busy never depend combinationally on start_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            start_ready <= (state_d == IDLE);
            busy        <= (state_d != IDLE);
            done        <= (state_d == DONE);
        end
    end

    // Operand shifters, carry flop, bit counter and result shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
        end else if (accept_c) begin
            // Subtract is a + ~b + 1: invert b once and seed the carry.
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
            opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
            res_q   <= {bit_s_c, res_q[WIDTH-1:1]};
            carry_q <= carry_nxt_c;
            cnt_q   <= cnt_q + CNT_W'(1);
            // Carry out of bit WIDTH-2 is the carry into the MSB.
            if (cnt_q == MSB_M1) begin
                msb_cin_q <= carry_nxt_c;
            end
        end
    end

    // Visible results update only once the last bit has been processed.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (last_bit_c) begin
            sum      <= {bit_s_c, res_q[WIDTH-1:1]};
            cout     <= carry_nxt_c;
            overflow <= msb_cin_q ^ carry_nxt_c;
        end
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor that reuses a single full-adder cell and a carry flip-flop to add two WIDTH-bit operands LSB-first, one bit per clock. It is the sequential successor to the single-bit full adder in the lab set. It adds operand width, subtract mode, a start/done handshake and signed-overflow detection. It sits between a register-file/operand source and any consumer that can tolerate WIDTH-cycle latency in exchange for minimal adder area.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- start_valid  in  1  request to begin an operation with the current a/b/cin/sub.
- start_ready  out  1  block can accept a request (high only in IDLE).
- a  in  WIDTH  operand A, sampled only on the accept edge.
- b  in  WIDTH  operand B, sampled only on the accept edge.
- cin  in  1  carry-in for add mode; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- sum  out  WIDTH  registered result, held until the next result is written.
- cout  out  1  carry out of MSB; in sub mode 1 means no borrow (a >= b unsigned).
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN and DONE.
- done  out  1  single-cycle pulse; sum/cout/overflow are valid and new.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- IDLE
  - start_ready=1, busy=0.
  - Accept occurs on an edge where start_valid && start_ready.
  - On accept: load shift regs opA<=a and opB<=(sub ? ~b : b); carry<=(sub ? 1 : cin); bit count<=0; state<=RUN.
- RUN
  - Each edge computes s=opA[0]^opB[0]^carry and carry<=majority(opA[0],opB[0],carry).
  - opA and opB shift right; s shifts into the MSB of the internal result shift register; count increments.
  - On the edge processing bit WIDTH-2, the carry into the MSB is captured for overflow.
  - On the edge processing bit WIDTH-1 (count==WIDTH-1):
    - sum<=final shifted result.
    - cout<=final carry.
    - overflow<=captured MSB carry-in XOR final carry.
    - state<=DONE.
- DONE
  - done=1 for exactly one cycle; next edge returns to IDLE.
  - A request is not accepted in DONE.
- sum/cout/overflow outputs never show partial results. They change only on the RUN→DONE edge and on reset.
- start_valid and input changes while busy are ignored. They have no effect on the operation in flight.
- All arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values (after a reset edge):
  - state=IDLE.
  - sum=0, cout=0, overflow=0.
  - done=0, busy=0, start_ready=1.
- Reset asserted mid-RUN or in DONE aborts the operation. No done pulse. Outputs are forced to reset values on that edge.
- Reset has priority over a simultaneous start_valid.
- Latency: with accept on edge E0, bits are processed on edges E1..E_WIDTH. done is high during the cycle following E_WIDTH. start_ready is high again after E_WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles with start_valid held high continuously.
- start_ready and busy are decoded from registered state only. They have no combinational path from start_valid.

## Test plan
- Reset: assert reset for 2 cycles with start_valid=1, then release. Required: all outputs at reset values, no accept during reset, start_ready=1 on the first cycle after release.
- Add with overflow (WIDTH=8): a=8'h3C, b=8'h55, cin=1, sub=0. Required: done exactly 8 edges after accept; sum=8'h92, cout=0, overflow=1.
- Carry wrap: a=8'hFF, b=8'h01, cin=0. Required: sum=8'h00, cout=1, overflow=0. Repeat with cin=1 and b=8'hFF; required: sum=8'hFF, cout=1.
- Subtract: a=8'h10, b=8'h20, sub=1, cin=1. Required: sum=8'hF0, cout=0, overflow=0 (cin is ignored). Then a=8'h80, b=8'h01. Required: sum=8'h7F, cout=1, overflow=1.
- Handshake and back-to-back:
  - Hold start_valid=1 and change a/b every cycle during RUN.
  - Required: only values present at accept edges are used, accepts are spaced exactly 10 cycles apart, and each done is one cycle wide.
  - Also run WIDTH=4 exhaustively over a, b, cin and sub against a reference model.
- Reset mid-operation: assert reset on the edge after bit 3 is processed. Required: no done pulse and outputs return to 0. A new request of 8'h01+8'h02 then yields sum=8'h03 normally.
